// File: rtl/pb_debounce_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pb_pkg
// Description : Shared constants and width helper for the push-button debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package pb_pkg;

    localparam int PB_CLK_DIV_1MS    = 25000;
    localparam int PB_STABLE_DEFAULT = 8;

    // Counter width for a 0..value-1 range, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pb_debounce_multi_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : pb_tick_gen
// Description : Free-running prescaler producing a one-cycle sample-enable tick.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_tick_gen
    import pb_pkg::*;
#(
    parameter int CLK_DIV = PB_CLK_DIV_1MS
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              DIV_W    = clog2_min1(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             at_last;

    assign at_last = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (at_last) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // Held low during reset so CLK_DIV=1 does not strobe while in reset.
    assign tick = at_last & ~rst;

endmodule
`default_nettype wire

// File: rtl/pb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : pb_debounce_multi
// Description : Multi-channel synchronous push-button debouncer with edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_debounce_multi
    import pb_pkg::*;
#(
    parameter int   N_CH        = 4,
    parameter int   CLK_DIV     = PB_CLK_DIV_1MS,
    parameter int   STABLE_CNT  = PB_STABLE_DEFAULT,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] button,
    output logic [N_CH-1:0] pb_level,
    output logic [N_CH-1:0] pb_rise,
    output logic [N_CH-1:0] pb_fall,
    output logic            tick
);

    localparam int               STAB_W    = clog2_min1(STABLE_CNT);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CNT - 1);

    pb_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic              s1_q;
        logic              s2_q;
        logic              level_q, level_d;
        logic [STAB_W-1:0] cnt_q, cnt_d;
        logic              rise_q, rise_d;
        logic              fall_q, fall_d;

        // Any tick sample that agrees with the current level drops progress.
        always_comb begin
            level_d = level_q;
            cnt_d   = cnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (tick) begin
                if (s2_q == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == STAB_LAST) begin
                    level_d = s2_q;
                    cnt_d   = '0;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                end else begin
                    cnt_d = cnt_q + STAB_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q    <= RESET_LEVEL;
                s2_q    <= RESET_LEVEL;
                level_q <= RESET_LEVEL;
                cnt_q   <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                s1_q    <= button[i];
                s2_q    <= s1_q;
                level_q <= level_d;
                cnt_q   <= cnt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign pb_level[i] = level_q;
        assign pb_rise[i]  = rise_q;
        assign pb_fall[i]  = fall_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pb_debounce_multi
// Description : Directed, table-driven bench for the multi-channel debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] button;
    logic [1:0] pb_level, pb_rise, pb_fall;
    logic       tick;

    logic       rst6;
    logic [0:0] btn6;
    logic [0:0] lvl6, rise6, fall6;
    logic       tick6;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pb_debounce_multi #(
        .N_CH        (2),
        .CLK_DIV     (4),
        .STABLE_CNT  (3),
        .RESET_LEVEL (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .button   (button),
        .pb_level (pb_level),
        .pb_rise  (pb_rise),
        .pb_fall  (pb_fall),
        .tick     (tick)
    );

    pb_debounce_multi #(
        .N_CH        (1),
        .CLK_DIV     (1),
        .STABLE_CNT  (1),
        .RESET_LEVEL (1'b1)
    ) dut6 (
        .clk      (clk),
        .rst      (rst6),
        .button   (btn6),
        .pb_level (lvl6),
        .pb_rise  (rise6),
        .pb_fall  (fall6),
        .tick     (tick6)
    );

    // Inputs held for n edges, outputs checked after the last one.
    typedef struct {
        logic       rst;
        logic [1:0] btn;
        int         n;
        logic [1:0] lvl;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       tck;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {lvl,rise,fall,tick}=%b expected %b", name, act, exp);
        end
    endtask

    function automatic logic b6(input int k);
        return logic'(((k - 1) / 3) % 2);
    endfunction

    initial begin
        logic exp_l;
        logic prev_l;

        rst    = 1'b1;
        button = 2'b00;
        rst6   = 1'b1;
        btn6   = 1'b1;

        // Idle sweep: tick every fourth cycle from cycle 3, no level activity.
        @(posedge clk); #1;
        check("idle_reset", {pb_level, pb_rise, pb_fall, tick}, 7'b0);
        rst = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            check($sformatf("idle_c%0d", c), {pb_level, pb_rise, pb_fall, tick},
                  {6'b0, (c % 4 == 3)});
        end

        //            rst   btn    n   lvl    rise   fall   tck
        tbl.push_back('{1'b1, 2'b00,  1, 2'b00, 2'b00, 2'b00, 1'b0}); // reset
        tbl.push_back('{1'b0, 2'b01,  3, 2'b00, 2'b00, 2'b00, 1'b1}); // first tick
        tbl.push_back('{1'b0, 2'b01,  8, 2'b00, 2'b00, 2'b00, 1'b1}); // two ticks counted
        tbl.push_back('{1'b0, 2'b01,  1, 2'b01, 2'b01, 2'b00, 1'b0}); // rise ch0
        tbl.push_back('{1'b0, 2'b01,  1, 2'b01, 2'b00, 2'b00, 1'b0}); // pulse ends
        tbl.push_back('{1'b0, 2'b11,  5, 2'b01, 2'b00, 2'b00, 1'b0}); // ch1 glitch
        tbl.push_back('{1'b0, 2'b01, 10, 2'b01, 2'b00, 2'b00, 1'b0}); // rejected
        tbl.push_back('{1'b0, 2'b11, 11, 2'b01, 2'b00, 2'b00, 1'b1}); // full count again
        tbl.push_back('{1'b0, 2'b11,  1, 2'b11, 2'b10, 2'b00, 1'b0}); // rise ch1
        tbl.push_back('{1'b0, 2'b11,  1, 2'b11, 2'b00, 2'b00, 1'b0});
        tbl.push_back('{1'b0, 2'b00, 10, 2'b11, 2'b00, 2'b00, 1'b1}); // release both
        tbl.push_back('{1'b0, 2'b00,  1, 2'b00, 2'b00, 2'b11, 1'b0}); // both fall
        tbl.push_back('{1'b0, 2'b00,  1, 2'b00, 2'b00, 2'b00, 1'b0});
        tbl.push_back('{1'b0, 2'b10,  7, 2'b00, 2'b00, 2'b00, 1'b0}); // ch1 two ticks in
        tbl.push_back('{1'b1, 2'b10,  1, 2'b00, 2'b00, 2'b00, 1'b0}); // mid-count reset
        tbl.push_back('{1'b0, 2'b10,  3, 2'b00, 2'b00, 2'b00, 1'b1});
        tbl.push_back('{1'b0, 2'b10,  8, 2'b00, 2'b00, 2'b00, 1'b1}); // count restarted
        tbl.push_back('{1'b0, 2'b10,  1, 2'b10, 2'b10, 2'b00, 1'b0});
        tbl.push_back('{1'b0, 2'b10,  1, 2'b10, 2'b00, 2'b00, 1'b0});
        tbl.push_back('{1'b1, 2'b00,  1, 2'b00, 2'b00, 2'b00, 1'b0}); // reset drops level, no fall

        foreach (tbl[v]) begin
            rst    = tbl[v].rst;
            button = tbl[v].btn;
            repeat (tbl[v].n) @(posedge clk);
            #1;
            check($sformatf("vec%0d", v), {pb_level, pb_rise, pb_fall, tick},
                  {tbl[v].lvl, tbl[v].rise, tbl[v].fall, tbl[v].tck});
        end

        // Fast instance: level tracks the synchronised input one cycle later.
        @(posedge clk); #1;
        check("fast_reset", {3'b0, lvl6, rise6, fall6, tick6}, 7'b0001000);
        rst6   = 1'b0;
        prev_l = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            btn6 = b6(k);
            @(posedge clk); #1;
            exp_l = (k < 3) ? 1'b1 : b6(k - 2);
            check($sformatf("fast_k%0d", k), {3'b0, lvl6, rise6, fall6, tick6},
                  {3'b0, exp_l, exp_l & ~prev_l, ~exp_l & prev_l, 1'b1});
            prev_l = exp_l;
        end
        rst6 = 1'b1;
        btn6 = 1'b0;
        @(posedge clk); #1;
        check("fast_rereset", {3'b0, lvl6, rise6, fall6, tick6}, 7'b0001000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
